// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS 32-bit words, per-register read-only
// selection, byte strobes, and one-cycle write/read pulses per register.
module axi_lite_regbank #(
  parameter int unsigned                    NUM_REGS     = 16,
  parameter int unsigned                    DATA_WIDTH   = 32,
  parameter int unsigned                    ADDR_WIDTH   = 8,
  parameter logic [NUM_REGS-1:0]            RO_MASK      = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_strobe,
  output logic [NUM_REGS-1:0]            rd_strobe
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Reject unsupported configurations at elaboration
  if (DATA_WIDTH != 32 || (64'(1) << IDX_W) < 64'(NUM_REGS)) begin : g_bad_cfg
    $error("axi_lite_regbank: unsupported DATA_WIDTH/ADDR_WIDTH/NUM_REGS combination");
  end

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held;
  logic [IDX_W-1:0]      aw_idx;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit_c;
  logic                  aw_held_n, bvalid_n, rvalid_n;
  logic [IDX_W-1:0]      ar_idx;
  logic [NUM_REGS-1:0]   aw_sel, ar_sel;
  logic                  aw_ok, ar_ok;
  logic [DATA_WIDTH-1:0] ar_data;
  logic                  unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs     = S_AXI_BVALID && S_AXI_BREADY;
  assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs     = S_AXI_RVALID && S_AXI_RREADY;
  assign commit_c = aw_held && w_held && !S_AXI_BVALID;
  assign ar_idx   = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  assign aw_held_n = b_hs ? 1'b0 : (aw_held || aw_hs);
  assign bvalid_n  = b_hs ? 1'b0 : (S_AXI_BVALID || commit_c);
  assign rvalid_n  = ar_hs ? 1'b1 : (r_hs ? 1'b0 : S_AXI_RVALID);

  // Address decode and read-data selection (RO slots read live status)
  always_comb begin
    aw_sel  = '0;
    ar_sel  = '0;
    ar_data = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      aw_sel[i] = (32'(aw_idx) == 32'(i));
      ar_sel[i] = (32'(ar_idx) == 32'(i));
      if (ar_sel[i]) begin
        ar_data = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
    aw_ok = |(aw_sel & ~RO_MASK);
    ar_ok = |ar_sel;
  end

  // Write channel: independent AW/W capture, commit, B response, write pulse
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held       <= 1'b0;
      aw_idx        <= '0;
      w_held        <= 1'b0;
      w_data        <= '0;
      w_strb        <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      wr_strobe     <= '0;
    end else begin
      wr_strobe <= '0;
      if (aw_hs) begin
        aw_idx <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit_c) begin
        S_AXI_BRESP <= aw_ok ? RESP_OKAY : RESP_SLVERR;
        if (aw_ok && |w_strb) begin
          wr_strobe <= aw_sel;
        end
      end
      aw_held       <= aw_held_n;
      w_held        <= b_hs ? 1'b0 : (w_held || w_hs);
      S_AXI_BVALID  <= bvalid_n;
      S_AXI_AWREADY <= !aw_held_n && !bvalid_n;
      S_AXI_WREADY  <= !(b_hs ? 1'b0 : (w_held || w_hs)) && !bvalid_n;
    end
  end

  // Register storage: byte-lane update of the addressed writable slot on commit
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= RO_MASK[i] ? '0 : RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (commit_c && aw_ok) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        for (int b = 0; b < int'(STRB_W); b++) begin
          if (aw_sel[i] && !RO_MASK[i] && w_strb[b]) begin
            regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read channel: registered response on AR handshake, held until R handshake
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      rd_strobe     <= '0;
    end else begin
      rd_strobe <= '0;
      if (ar_hs) begin
        S_AXI_RDATA <= ar_data;
        S_AXI_RRESP <= ar_ok ? RESP_OKAY : RESP_SLVERR;
        rd_strobe   <= ar_sel;
      end
      S_AXI_RVALID  <= rvalid_n;
      S_AXI_ARREADY <= !rvalid_n;
    end
  end

  // Software-visible register contents; RO slots always present zero
  always_comb begin
    ctrl_out = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      ctrl_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: table-driven AXI-Lite transactions
// with response scoreboards, plus hand-written ordering, stall and reset cases.
module tb_axi_lite_regbank;

  localparam int unsigned NR = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam logic [NR-1:0]    RO  = 16'h0020;
  localparam logic [NR*DW-1:0] RST = 512'(32'hDEADBEEF) << 96;
  localparam int LIMIT = 100;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic [AW-1:0] S_AXI_AWADDR = '0;
  logic [2:0] S_AXI_AWPROT = '0;
  logic S_AXI_AWVALID = 1'b0;
  logic S_AXI_AWREADY;
  logic [DW-1:0] S_AXI_WDATA = '0;
  logic [DW/8-1:0] S_AXI_WSTRB = '0;
  logic S_AXI_WVALID = 1'b0;
  logic S_AXI_WREADY;
  logic [1:0] S_AXI_BRESP;
  logic S_AXI_BVALID;
  logic S_AXI_BREADY = 1'b0;
  logic [AW-1:0] S_AXI_ARADDR = '0;
  logic [2:0] S_AXI_ARPROT = '0;
  logic S_AXI_ARVALID = 1'b0;
  logic S_AXI_ARREADY;
  logic [DW-1:0] S_AXI_RDATA;
  logic [1:0] S_AXI_RRESP;
  logic S_AXI_RVALID;
  logic S_AXI_RREADY = 1'b0;
  logic [NR*DW-1:0] ctrl_out;
  logic [NR*DW-1:0] status_in;
  logic [NR-1:0] wr_strobe;
  logic [NR-1:0] rd_strobe;

  axi_lite_regbank #(
    .NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RO_MASK(RO), .RESET_VALUES(RST)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ctrl_out(ctrl_out), .status_in(status_in),
    .wr_strobe(wr_strobe), .rd_strobe(rd_strobe)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    int          exp_strobe;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  vec_t       vecs[$];
  rexp_t      rq[$];
  logic [1:0] bq[$];

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0, wr_last = -1;
  int rd_pulses = 0, rd_last = -1;

  // Count strobe pulses once per cycle, away from the active edge
  always @(negedge ACLK) begin
    for (int i = 0; i < int'(NR); i++) begin
      if (wr_strobe[i]) begin wr_pulses++; wr_last = i; end
      if (rd_strobe[i]) begin rd_pulses++; rd_last = i; end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp, input int exp_strobe,
                          input int aw_dly, input int w_dly, input int b_stall);
    int  cyc = 0;
    int  lat = 0;
    int  p0  = wr_pulses;
    bit  aw_pend = 1'b1, w_pend = 1'b1, aw_go, w_go;
    bq.push_back(exp_resp);
    while ((aw_pend || w_pend) && cyc < LIMIT) begin
      if (aw_pend && cyc == aw_dly) begin S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = addr; end
      if (w_pend && cyc == w_dly) begin S_AXI_WVALID = 1'b1; S_AXI_WDATA = data; S_AXI_WSTRB = strb; end
      aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
      w_go  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK);
      cyc++;
      if (aw_go) begin S_AXI_AWVALID = 1'b0; aw_pend = 1'b0; end
      if (w_go)  begin S_AXI_WVALID = 1'b0;  w_pend = 1'b0;  end
      if (!aw_pend && w_pend) check("awready_low_while_held", 64'(S_AXI_AWREADY), 64'd0);
      if (!w_pend && aw_pend) check("wready_low_while_held", 64'(S_AXI_WREADY), 64'd0);
    end
    if (aw_pend || w_pend) begin timeout("write_addr_data"); S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; end
    while (!S_AXI_BVALID && lat < LIMIT) begin @(negedge ACLK); lat++; end
    if (!S_AXI_BVALID) begin timeout("write_resp"); void'(bq.pop_front()); return; end
    check("bvalid_latency", 64'(lat), 64'd1);
    for (int s = 0; s < b_stall; s++) begin
      S_AXI_AWVALID = 1'b1;
      S_AXI_AWADDR  = 8'h30;
      check("bvalid_held", 64'(S_AXI_BVALID), 64'd1);
      check("no_aw_during_b", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'd0);
      @(negedge ACLK);
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_BREADY  = 1'b1;
    check("bresp", 64'(S_AXI_BRESP), 64'(bq.pop_front()));
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check("awready_after_b", 64'(S_AXI_AWREADY), 64'd1);
    check("wr_strobe_count", 64'(wr_pulses - p0), (exp_strobe >= 0) ? 64'd1 : 64'd0);
    if (exp_strobe >= 0) check("wr_strobe_idx", 64'(wr_last), 64'(exp_strobe));
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                         input int exp_strobe, input int r_stall);
    int    n  = 0;
    int    p0 = rd_pulses;
    rexp_t e;
    rq.push_back('{data: exp_data, resp: exp_resp});
    S_AXI_ARVALID = 1'b1;
    S_AXI_ARADDR  = addr;
    while (!S_AXI_ARREADY && n < LIMIT) begin @(negedge ACLK); n++; end
    if (!S_AXI_ARREADY) begin timeout("read_addr"); S_AXI_ARVALID = 1'b0; void'(rq.pop_front()); return; end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("rvalid_latency", 64'(S_AXI_RVALID), 64'd1);
    e = rq.pop_front();
    for (int s = 0; s < r_stall; s++) begin
      @(negedge ACLK);
      check("rdata_stable", 64'({S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RDATA}), 64'({1'b1, 1'b0, e.data}));
    end
    S_AXI_RREADY = 1'b1;
    check("rdata", 64'(S_AXI_RDATA), 64'(e.data));
    check("rresp", 64'(S_AXI_RRESP), 64'(e.resp));
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    check("arready_after_r", 64'({S_AXI_ARREADY, S_AXI_RVALID}), 64'b10);
    check("rd_strobe_count", 64'(rd_pulses - p0), (exp_strobe >= 0) ? 64'd1 : 64'd0);
    if (exp_strobe >= 0) check("rd_strobe_idx", 64'(rd_last), 64'(exp_strobe));
  endtask

  function automatic void add(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic [1:0] r, input logic [31:0] x, input int st);
    vecs.push_back('{is_wr: w, addr: a, data: d, strb: s, exp_resp: r, exp_data: x, exp_strobe: st});
  endfunction

  initial begin
    status_in = '0;
    for (int i = 0; i < int'(NR); i++) status_in[i*DW +: DW] = 32'hBAD00000 | 32'(i);
    status_in[5*DW +: DW] = 32'h12345678;

    // Table: reset value, sequential writes/readback, byte strobes, RO, out of range
    add(0, 8'h0C, 0, 0, 2'b00, 32'hDEADBEEF, 3);
    add(1, 8'h00, 32'h1, 4'hF, 2'b00, 0, 0);
    add(1, 8'h04, 32'h2, 4'hF, 2'b00, 0, 1);
    add(1, 8'h08, 32'h3, 4'hF, 2'b00, 0, 2);
    add(1, 8'h0C, 32'h4, 4'hF, 2'b00, 0, 3);
    add(0, 8'h00, 0, 0, 2'b00, 32'h1, 0);
    add(0, 8'h04, 0, 0, 2'b00, 32'h2, 1);
    add(0, 8'h08, 0, 0, 2'b00, 32'h3, 2);
    add(0, 8'h0C, 0, 0, 2'b00, 32'h4, 3);
    add(1, 8'h08, 32'hAABBCCDD, 4'hF, 2'b00, 0, 2);
    add(1, 8'h08, 32'h11223344, 4'b0101, 2'b00, 0, 2);
    add(0, 8'h08, 0, 0, 2'b00, 32'hAA22CC44, 2);
    add(1, 8'h14, 32'hFFFFFFFF, 4'hF, 2'b10, 0, -1);
    add(0, 8'h14, 0, 0, 2'b00, 32'h12345678, 5);
    add(1, 8'h40, 32'h0BADF00D, 4'hF, 2'b10, 0, -1);
    add(0, 8'h40, 0, 0, 2'b10, 32'h0, -1);
    add(0, 8'hFC, 0, 0, 2'b10, 32'h0, -1);
    add(1, 8'h18, 32'hCAFEF00D, 4'h0, 2'b00, 0, -1);
    add(0, 8'h18, 0, 0, 2'b00, 32'h0, 6);
    add(1, 8'h07, 32'h00000055, 4'hF, 2'b00, 0, 1);
    add(0, 8'h04, 0, 0, 2'b00, 32'h55, 1);
    add(0, 8'h3C, 0, 0, 2'b00, 32'h0, 15);
    add(1, 8'h3C, 32'h80000001, 4'hF, 2'b00, 0, 15);
    add(0, 8'h3C, 0, 0, 2'b00, 32'h80000001, 15);

    // Reset held 200 ns
    #200;
    check("rst_ready", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'd0);
    check("rst_valid", 64'({S_AXI_BVALID, S_AXI_RVALID, wr_strobe, rd_strobe}), 64'd0);
    check("rst_ctrl3", 64'(ctrl_out[3*DW +: DW]), 64'h0DEADBEEF);
    check("rst_ctrl0", 64'(ctrl_out[0 +: DW]), 64'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("ready_after_rst", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'b111);
    repeat (2) @(negedge ACLK);

    foreach (vecs[k]) begin
      if (vecs[k].is_wr)
        do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].exp_resp, vecs[k].exp_strobe, 0, 0, 0);
      else
        do_read(vecs[k].addr, vecs[k].exp_data, vecs[k].exp_resp, vecs[k].exp_strobe, 0);
    end

    check("ctrl0", 64'(ctrl_out[0*DW +: DW]), 64'h1);
    check("ctrl1", 64'(ctrl_out[1*DW +: DW]), 64'h55);
    check("ctrl2", 64'(ctrl_out[2*DW +: DW]), 64'hAA22CC44);
    check("ctrl5_ro_zero", 64'(ctrl_out[5*DW +: DW]), 64'h0);
    check("ctrl15", 64'(ctrl_out[15*DW +: DW]), 64'h80000001);

    // AW three cycles ahead of W, then W ahead of AW, each with a stalled BREADY
    do_write(8'h20, 32'hA5A50001, 4'hF, 2'b00, 8, 0, 3, 5);
    do_write(8'h24, 32'h5A5A0002, 4'hF, 2'b00, 9, 2, 0, 5);
    do_read(8'h20, 32'hA5A50001, 2'b00, 8, 3);
    do_read(8'h24, 32'h5A5A0002, 2'b00, 9, 0);
    check("no_stray_write_0x30", 64'(ctrl_out[12*DW +: DW]), 64'h0);

    // Reset asserted while a read response is pending
    S_AXI_ARVALID = 1'b1;
    S_AXI_ARADDR  = 8'h00;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("midrd_rvalid", 64'(S_AXI_RVALID), 64'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    check("midrd_rvalid_drop", 64'({S_AXI_RVALID, S_AXI_ARREADY, S_AXI_AWREADY}), 64'd0);
    check("midrd_rdata_zero", 64'(S_AXI_RDATA), 64'd0);
    check("midrd_ctrl_reset", 64'(ctrl_out[0 +: DW]), 64'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    check("post_rst_idle", 64'({S_AXI_ARREADY, S_AXI_RVALID, S_AXI_BVALID}), 64'b100);
    do_read(8'h0C, 32'hDEADBEEF, 2'b00, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank; successor to the fixed four-register ospreyUDP slave. Provides NUM_REGS control/status words with per-register read-only selection, byte strobes, and per-register write/read pulses. Error responses cover out-of-range and illegal writes. Sits between the AXI interconnect and UDP/datapath logic as the standard software-visible register front end.

Parameters:
NUM_REGS, 16, number of 32-bit-aligned register slots (2..256)
DATA_WIDTH, 32, AXI data width; only 32 supported, checked at elaboration
ADDR_WIDTH, 8, AXI address width; must satisfy 2^(ADDR_WIDTH-2) >= NUM_REGS
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only (reads status_in slice i)
RESET_VALUES, 0, NUM_REGS*DATA_WIDTH flattened reset values for writable registers

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
ctrl_out  out  NUM_REGS*DATA_WIDTH  register contents, slice i = register i
status_in  in  NUM_REGS*DATA_WIDTH  live values for RO registers
wr_strobe  out  NUM_REGS  one-cycle pulse per committed write
rd_strobe  out  NUM_REGS  one-cycle pulse per completed read

Behaviour:
- Reset (ARESETN low, async): all *VALID/*READY outputs 0 except AWREADY/WREADY/ARREADY = 1 one cycle after release; BRESP/RRESP/RDATA = 0; strobes 0; ctrl_out = RESET_VALUES (RO slices 0). Reset mid-transaction abandons all captured state; no response is issued.
- Index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
- Write path: AW and W captured independently in holding registers; AWREADY low once AW held, WREADY low once W held, both low while BVALID high. Either order, or same cycle.
- Commit: edge after both held: register updated (byte lanes with WSTRB=1 only), BVALID rises, wr_strobe[i] high for exactly that following cycle. Latency: 1 cycle from last of AW/W handshake to BVALID.
- BRESP: OKAY (00) for writable in-range index; SLVERR (10) for index >= NUM_REGS or RO_MASK[i]=1 — no register change, no wr_strobe. WSTRB=0 on writable: OKAY, no change, no strobe.
- BVALID holds until BREADY; holding registers free at B handshake; AW/WREADY reassert next cycle (max 1 write outstanding).
- Read path: ARREADY high when RVALID low. AR handshake edge registers RDATA/RRESP and raises RVALID (latency 1). RDATA = ctrl_out slice (writable) or status_in slice sampled at that edge (RO). Out-of-range: RDATA 0, RRESP SLVERR, no strobe. rd_strobe[i] high for first RVALID cycle only, OKAY reads only.
- RVALID/RDATA stable until RREADY; ARREADY reasserts the cycle after R handshake.
- Simultaneous read and write to same index: channels independent; read returns pre-commit value if AR handshake edge is at or before commit edge.
- No combinational path from any input to any AXI output.

Test Plan:
- Reset: ARESETN low 200 ns, RESET_VALUES slice 3 = 0xDEADBEEF -> read addr 0x0C returns 0xDEADBEEF, RRESP 00.
- Sequential write 0x1..0x4 to addr 0x00..0x0C, read back -> data matches, BRESP/RRESP 00, wr_strobe[0..3] each one pulse.
- AW three cycles before W, then W before AW, with BREADY stalled 5 cycles -> one commit each, BVALID held, no second AW accepted while BVALID high.
- Reg 2 holds 0xAABBCCDD, write 0x11223344 WSTRB=0101 -> reads 0xAA22CC44.
- RO_MASK bit 5 set, status_in slice 5 = 0x12345678, write 0xFFFFFFFF to 0x14 -> BRESP 10, read returns 0x12345678.
- Read/write 0x40 (index 16, NUM_REGS=16) -> RRESP 10 with RDATA 0, BRESP 10, no strobes; assert ARESETN low mid-read -> RVALID drops immediately.
